// File: rtl/latch_bank_ctrl_pkg.sv
// Shared types and defaults for the latch bank write sequencer.
// Optional readback check is enabled by defining LATCH_BANK_READBACK_EN.
package latch_bank_ctrl_pkg;

    localparam int DEF_NREQ     = 4;
    localparam int DEF_DW       = 8;
    localparam int DEF_NENT     = 4;
    localparam int DEF_AW       = 2;
    localparam int DEF_OPEN_CYC = 2;
    localparam int DEF_HOLD_CYC = 1;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        SETUP  = 3'd1,
        OPEN   = 3'd2,
        HOLD   = 3'd3,
        VERIFY = 3'd4,
        ACK    = 3'd5
    } state_t;

    function automatic int phase_cnt_w(input int open_cyc, input int hold_cyc);
        int m;
        m = (open_cyc > hold_cyc) ? open_cyc : hold_cyc;
        return (m < 1) ? 1 : $clog2(m + 1);
    endfunction

endpackage

// File: rtl/latch_bank_ctrl_arb.sv
// Combinational round-robin arbiter: first requester at or after ptr wins.
module rr_arbiter #(
    parameter int NREQ = 4,
    parameter int PW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic [NREQ-1:0] req,
    input  logic [PW-1:0]   ptr,
    output logic [NREQ-1:0] gnt,
    output logic [PW-1:0]   idx,
    output logic            valid
);

    // Rotating priority search starting at the pointer
    always_comb begin
        gnt   = '0;
        idx   = '0;
        valid = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            int  j;
            logic hit;
            j      = (int'(ptr) + k) % NREQ;
            hit    = !valid && req[j];
            gnt[j] = hit;
            idx    = hit ? PW'(j) : idx;
            valid  = valid | hit;
        end
    end

endmodule

// File: rtl/latch_bank_ctrl.sv
// Arbitrated SETUP/OPEN/HOLD write sequencer for a bank of transparent-high latches.
// Define LATCH_BANK_READBACK_EN to add the lat_q readback check and sticky err.
module latch_bank_ctrl
    import latch_bank_ctrl_pkg::*;
#(
    parameter int NREQ     = DEF_NREQ,
    parameter int DW       = DEF_DW,
    parameter int NENT     = DEF_NENT,
    parameter int AW       = DEF_AW,
    parameter int OPEN_CYC = DEF_OPEN_CYC,
    parameter int HOLD_CYC = DEF_HOLD_CYC
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NREQ-1:0]    req,
    input  logic [NREQ*AW-1:0] req_addr,
    input  logic [NREQ*DW-1:0] req_data,
`ifdef LATCH_BANK_READBACK_EN
    input  logic [DW-1:0]      lat_q,
    output logic               err,
`endif
    output logic [NREQ-1:0]    gnt,
    output logic [NREQ-1:0]    ack,
    output logic [DW-1:0]      lat_d,
    output logic [NENT-1:0]    lat_en,
    output logic               busy
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int CW = phase_cnt_w(OPEN_CYC, HOLD_CYC);

    state_t          r_state, w_state_nxt;
    logic [CW-1:0]   r_cnt, w_cnt_nxt;
    logic [PW-1:0]   r_ptr, r_idx, w_ptr_nxt, w_arb_idx;
    logic [AW-1:0]   r_addr;
    logic [DW-1:0]   r_lat_d;
    logic [NREQ-1:0] r_gnt, r_ack, w_arb_gnt, w_gnt_nxt, w_ack_nxt, w_idx_oh;
    logic [NENT-1:0] r_lat_en, w_lat_en_nxt, w_dec;
    logic            r_busy, w_arb_valid, w_capture;

    rr_arbiter #(.NREQ(NREQ), .PW(PW)) u_arb (
        .req   (req),
        .ptr   (r_ptr),
        .gnt   (w_arb_gnt),
        .idx   (w_arb_idx),
        .valid (w_arb_valid)
    );

    // Phase sequencing; the counter reloads on entry to each timed phase
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_capture   = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_arb_valid) begin
                    w_state_nxt = SETUP;
                    w_capture   = 1'b1;
                end else begin
                    w_state_nxt = IDLE;
                end
            end
            SETUP: begin
                w_state_nxt = OPEN;
                w_cnt_nxt   = CW'(OPEN_CYC - 1);
            end
            OPEN: begin
                if (r_cnt == '0) begin
                    w_state_nxt = HOLD;
                    w_cnt_nxt   = CW'(HOLD_CYC - 1);
                end else begin
                    w_cnt_nxt = r_cnt - CW'(1);
                end
            end
            HOLD: begin
                if (r_cnt == '0) begin
`ifdef LATCH_BANK_READBACK_EN
                    w_state_nxt = VERIFY;
`else
                    w_state_nxt = ACK;
`endif
                end else begin
                    w_cnt_nxt = r_cnt - CW'(1);
                end
            end
            VERIFY:  w_state_nxt = ACK;
            ACK:     w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // Next values for the registered outputs, derived from the next state
    always_comb begin
        w_dec    = '0;
        w_idx_oh = '0;
        for (int e = 0; e < NENT; e++) begin
            w_dec[e] = (int'(r_addr) == e);
        end
        for (int i = 0; i < NREQ; i++) begin
            w_idx_oh[i] = (int'(r_idx) == i);
        end
        if (w_state_nxt == IDLE) begin
            w_gnt_nxt = '0;
        end else if (w_capture) begin
            w_gnt_nxt = w_arb_gnt;
        end else begin
            w_gnt_nxt = r_gnt;
        end
        w_lat_en_nxt = (w_state_nxt == OPEN) ? w_dec : '0;
        w_ack_nxt    = (w_state_nxt == ACK) ? w_idx_oh : '0;
        w_ptr_nxt    = (r_idx == PW'(NREQ - 1)) ? '0 : r_idx + PW'(1);
    end

    // State, capture registers and output flops
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= IDLE;
            r_cnt    <= '0;
            r_ptr    <= '0;
            r_idx    <= '0;
            r_addr   <= '0;
            r_lat_d  <= '0;
            r_gnt    <= '0;
            r_ack    <= '0;
            r_lat_en <= '0;
            r_busy   <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_cnt    <= w_cnt_nxt;
            r_gnt    <= w_gnt_nxt;
            r_ack    <= w_ack_nxt;
            r_lat_en <= w_lat_en_nxt;
            r_busy   <= (w_state_nxt != IDLE);
            if (w_capture) begin
                r_idx   <= w_arb_idx;
                r_addr  <= req_addr[w_arb_idx*AW +: AW];
                r_lat_d <= req_data[w_arb_idx*DW +: DW];
            end
            if (r_state == ACK) begin
                r_ptr <= w_ptr_nxt;
            end
        end
    end

`ifdef LATCH_BANK_READBACK_EN
    logic r_err;

    // Sticky readback mismatch flag, sampled in VERIFY
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_err <= 1'b0;
        end else if (r_state == VERIFY && lat_q != r_lat_d) begin
            r_err <= 1'b1;
        end
    end

    assign err = r_err;
`endif

    assign gnt    = r_gnt;
    assign ack    = r_ack;
    assign lat_d  = r_lat_d;
    assign lat_en = r_lat_en;
    assign busy   = r_busy;

endmodule
